// File: rtl/track_pooler_if.sv
// ============================================================================
// Module   : track_pooler_if
// Purpose  : Capture/result bundle between the stroke source and track_pooler.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface track_pooler_if #(
    parameter int GRID = 52,
    parameter int POOL = 4
);
    localparam int CELLS = GRID / POOL;
    localparam int NBITS = GRID * GRID;
    localparam int NFEAT = CELLS * CELLS;
    localparam int INKW  = $clog2(NBITS + 1);

    logic              track_valid;
    logic [NBITS-1:0]  track_in;
    logic [3:0]        blk_x_in;
    logic [3:0]        blk_y_in;
    logic              busy;
    logic              feat_valid;
    logic [NFEAT-1:0]  feat;
    logic [INKW-1:0]   ink_count;
    logic              feat_empty;
    logic [3:0]        blk_x;
    logic [3:0]        blk_y;
    logic              overrun;

    modport master (
        output track_valid, track_in, blk_x_in, blk_y_in,
        input  busy, feat_valid, feat, ink_count, feat_empty, blk_x, blk_y, overrun
    );

    modport slave (
        input  track_valid, track_in, blk_x_in, blk_y_in,
        output busy, feat_valid, feat, ink_count, feat_empty, blk_x, blk_y, overrun
    );
endinterface

`default_nettype wire

// File: rtl/track_pooler.sv
// ============================================================================
// Module   : track_pooler
// Purpose  : Captures a stroke bitmap, pools it window-by-window into a
//            thresholded occupancy map and totals the ink.
// Revision : 1.0
// ============================================================================
`default_nettype none

module track_pooler #(
    parameter int GRID   = 52,
    parameter int POOL   = 4,
    parameter int THRESH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    track_pooler_if.slave  bus
);
    localparam int CELLS = GRID / POOL;
    localparam int NBITS = GRID * GRID;
    localparam int NFEAT = CELLS * CELLS;
    localparam int INKW  = $clog2(NBITS + 1);
    localparam int IDXW  = $clog2(NBITS);
    localparam int SUMW  = $clog2(POOL * POOL + 1);
    localparam int CELLW = $clog2(NFEAT);
    localparam int CW    = $clog2(CELLS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NBITS-1:0]   track_q;
    logic [3:0]         bx_q, by_q;
    logic [CELLW-1:0]   cell_q;
    logic [CW-1:0]      cx_q, cy_q;
    logic [INKW-1:0]    ink_q;
    logic [NFEAT-1:0]   work_q;
    logic [NFEAT-1:0]   feat_q;
    logic [INKW-1:0]    ink_out_q;
    logic               empty_q;
    logic [3:0]         blk_x_q, blk_y_q;

    logic [IDXW-1:0]    w_base;
    logic [SUMW-1:0]    w_sum;
    logic               w_last;
    logic [NFEAT-1:0]   w_work_upd;
    logic [INKW-1:0]    w_ink_upd;

    // Popcount of the current POOL x POOL window.
    always_comb begin
        w_base = IDXW'(int'(cy_q) * POOL * GRID + int'(cx_q) * POOL);
        w_sum  = '0;
        for (int r = 0; r < POOL; r++) begin
            for (int c = 0; c < POOL; c++) begin
                w_sum = w_sum + SUMW'(track_q[w_base + IDXW'(r * GRID + c)]);
            end
        end
    end

    assign w_last     = (cell_q == CELLW'(NFEAT - 1));
    assign w_work_upd = work_q | (NFEAT'(w_sum >= SUMW'(THRESH)) << cell_q);
    assign w_ink_upd  = ink_q + INKW'(w_sum);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.track_valid) state_d = SCAN;
            SCAN:    if (w_last)          state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            track_q   <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            cell_q    <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            ink_q     <= '0;
            work_q    <= '0;
            feat_q    <= '0;
            ink_out_q <= '0;
            empty_q   <= 1'b0;
            blk_x_q   <= '0;
            blk_y_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.track_valid) begin
                        track_q <= bus.track_in;
                        bx_q    <= bus.blk_x_in;
                        by_q    <= bus.blk_y_in;
                        cell_q  <= '0;
                        cx_q    <= '0;
                        cy_q    <= '0;
                        ink_q   <= '0;
                        work_q  <= '0;
                    end
                end
                SCAN: begin
                    work_q <= w_work_upd;
                    ink_q  <= w_ink_upd;
                    cell_q <= cell_q + 1'b1;
                    if (cx_q == CW'(CELLS - 1)) begin
                        cx_q <= '0;
                        cy_q <= cy_q + 1'b1;
                    end else begin
                        cx_q <= cx_q + 1'b1;
                    end
                    // Results publish on the edge entering DONE, so they are valid with feat_valid.
                    if (w_last) begin
                        feat_q    <= w_work_upd;
                        ink_out_q <= w_ink_upd;
                        empty_q   <= (w_ink_upd == '0);
                        blk_x_q   <= bx_q;
                        blk_y_q   <= by_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.feat_valid = (state_q == DONE);
    assign bus.overrun    = bus.track_valid && (state_q != IDLE);
    assign bus.feat       = feat_q;
    assign bus.ink_count  = ink_out_q;
    assign bus.feat_empty = empty_q;
    assign bus.blk_x      = blk_x_q;
    assign bus.blk_y      = blk_y_q;
endmodule

`default_nettype wire

// File: tb/tb_track_pooler.sv
// ============================================================================
// Module   : tb_track_pooler
// Purpose  : Self-checking bench for track_pooler: directed table, random
//            bitmaps against a pixel-level model, and multi-cycle sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_track_pooler;
    localparam int GRID   = 52;
    localparam int POOL   = 4;
    localparam int THRESH = 2;
    localparam int CELLS  = GRID / POOL;
    localparam int NBITS  = GRID * GRID;
    localparam int NFEAT  = CELLS * CELLS;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    track_pooler_if #(.GRID(GRID), .POOL(POOL)) bus ();

    track_pooler #(.GRID(GRID), .POOL(POOL), .THRESH(THRESH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [NBITS-1:0] bm;
        logic [3:0]       bx;
        logic [3:0]       by;
        logic [NFEAT-1:0] exp_feat;
        logic [11:0]      exp_ink;
        logic             exp_empty;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Pixel-centric reference: each set pixel bumps its window's tally.
    task automatic model(input logic [NBITS-1:0] bm, output logic [NFEAT-1:0] f, output int ink);
        int cnt[NFEAT];
        for (int i = 0; i < NFEAT; i++) cnt[i] = 0;
        ink = 0;
        for (int y = 0; y < GRID; y++) begin
            for (int x = 0; x < GRID; x++) begin
                if (bm[y * GRID + x]) begin
                    cnt[(y / POOL) * CELLS + x / POOL]++;
                    ink++;
                end
            end
        end
        for (int i = 0; i < NFEAT; i++) f[i] = (cnt[i] >= THRESH);
    endtask

    task automatic capture(input logic [NBITS-1:0] bm, input logic [3:0] bx, input logic [3:0] by,
                           output int lat);
        @(negedge clk);
        bus.track_valid = 1'b1;
        bus.track_in    = bm;
        bus.blk_x_in    = bx;
        bus.blk_y_in    = by;
        lat = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            bus.track_valid = 1'b0;
            if (bus.feat_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    function automatic logic [NBITS-1:0] px(input logic [NBITS-1:0] bm, input int x, input int y);
        logic [NBITS-1:0] b;
        b = bm;
        b[y * GRID + x] = 1'b1;
        return b;
    endfunction

    initial begin
        logic [NBITS-1:0] bm_a, bm_b, bm_r;
        logic [NFEAT-1:0] mf_a, mf_b, mf_r;
        int               mi_a, mi_b, mi_r;
        int               lat, pulses, dens;

        n_cmp = 0;
        n_err = 0;

        vecs[0] = '{"zero",     '0, 4'd3, 4'd5, '0, 12'd0, 1'b1};
        vecs[1] = '{"ones",     '1, 4'd1, 4'd2, '1, 12'd2704, 1'b0};
        vecs[2] = '{"px00",     px('0, 0, 0), 4'd0, 4'd0, '0, 12'd1, 1'b0};
        vecs[3] = '{"px00_11",  px(px('0, 0, 0), 1, 1), 4'd8, 4'd8, '0, 12'd2, 1'b0};
        vecs[3].exp_feat[0] = 1'b1;
        vecs[4] = '{"corner",   px(px('0, 51, 51), 50, 51), 4'd7, 4'd0, '0, 12'd2, 1'b0};
        vecs[4].exp_feat[168] = 1'b1;
        vecs[5] = '{"vline",    '0, 4'd4, 4'd6, '0, 12'd52, 1'b0};
        for (int y = 0; y < GRID; y++) vecs[5].bm[y * GRID + 26] = 1'b1;
        for (int cy = 0; cy < CELLS; cy++) vecs[5].exp_feat[cy * CELLS + 6] = 1'b1;
        vecs[6] = '{"blk_pass", px(px(px('0, 10, 20), 11, 20), 40, 3), 4'd15, 4'd9, '0, 12'd3, 1'b0};
        vecs[6].exp_feat[5 * CELLS + 2] = 1'b1;

        bus.track_valid = 1'b0;
        bus.track_in    = '0;
        bus.blk_x_in    = '0;
        bus.blk_y_in    = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  {255'd0, bus.busy}, 256'd0);
        chk("rst_fv",    {255'd0, bus.feat_valid}, 256'd0);
        chk("rst_outs",  {bus.feat, bus.ink_count, bus.feat_empty, bus.blk_x, bus.blk_y, bus.overrun}, 256'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            capture(vecs[i].bm, vecs[i].bx, vecs[i].by, lat);
            chk({vecs[i].name, "_lat"},   256'(lat), 256'd170);
            chk({vecs[i].name, "_feat"},  256'(bus.feat), 256'(vecs[i].exp_feat));
            chk({vecs[i].name, "_ink"},   256'(bus.ink_count), 256'(vecs[i].exp_ink));
            chk({vecs[i].name, "_empty"}, 256'(bus.feat_empty), 256'(vecs[i].exp_empty));
            chk({vecs[i].name, "_blk"},   256'({bus.blk_x, bus.blk_y}), 256'({vecs[i].bx, vecs[i].by}));
        end

        for (int t = 0; t < 12; t++) begin
            dens = $urandom_range(0, 40);
            for (int b = 0; b < NBITS; b++) bm_r[b] = ($urandom_range(0, 99) < dens);
            model(bm_r, mf_r, mi_r);
            capture(bm_r, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), lat);
            chk("rnd_lat",   256'(lat), 256'd170);
            chk("rnd_feat",  256'(bus.feat), 256'(mf_r));
            chk("rnd_ink",   256'(bus.ink_count), 256'(mi_r));
            chk("rnd_empty", 256'(bus.feat_empty), 256'(mi_r == 0));
        end

        // Overrun during scan, then back-to-back acceptance right after DONE.
        for (int b = 0; b < NBITS; b++) bm_a[b] = ($urandom_range(0, 99) < 20);
        for (int b = 0; b < NBITS; b++) bm_b[b] = ($urandom_range(0, 99) < 30);
        model(bm_a, mf_a, mi_a);
        model(bm_b, mf_b, mi_b);
        @(negedge clk);
        bus.track_valid = 1'b1;
        bus.track_in    = bm_a;
        pulses = 0;
        for (int n = 1; n <= 341; n++) begin
            @(negedge clk);
            bus.track_valid = 1'b0;
            if (bus.feat_valid && n < 341) pulses++;
            if (n == 170) begin
                chk("ovr_fv170",  256'(bus.feat_valid), 256'd1);
                chk("ovr_feat_a", 256'(bus.feat), 256'(mf_a));
                chk("ovr_ink_a",  256'(bus.ink_count), 256'(mi_a));
            end
            if (n == 100) begin
                bus.track_valid = 1'b1;
                bus.track_in    = bm_b;
                #1;
                chk("ovr_pulse", 256'({bus.overrun, bus.busy}), 256'd3);
            end
            if (n == 101) begin
                #1;
                chk("ovr_clear", 256'(bus.overrun), 256'd0);
            end
            if (n == 171) begin
                bus.track_valid = 1'b1;
                bus.track_in    = bm_b;
                #1;
                chk("b2b_noovr", 256'(bus.overrun), 256'd0);
            end
            if (n == 250) chk("hold_feat", 256'(bus.feat), 256'(mf_a));
            if (n == 341) begin
                chk("b2b_fv341", 256'(bus.feat_valid), 256'd1);
                chk("b2b_feat",  256'(bus.feat), 256'(mf_b));
                chk("b2b_ink",   256'(bus.ink_count), 256'(mi_b));
            end
        end
        chk("ovr_pulses", 256'(pulses), 256'd1);

        // Reset while cell 50 is being scanned aborts silently.
        @(negedge clk);
        bus.track_valid = 1'b1;
        bus.track_in    = '1;
        for (int n = 1; n <= 51; n++) begin
            @(negedge clk);
            bus.track_valid = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 256'(bus.busy), 256'd0);
        chk("mid_rst_outs", {bus.feat, bus.ink_count, bus.feat_empty, bus.blk_x, bus.blk_y, bus.feat_valid}, 256'd0);
        rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.feat_valid || bus.busy) pulses++;
        end
        chk("mid_rst_quiet", 256'(pulses), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
